// File: rtl/sar_pkg.sv
// Shared types and default sizing for the store_and_release buffer.
package sar_pkg;

  localparam int DATA_W_DEF = 64;
  localparam int DEPTH_DEF  = 8;
  localparam int IDX_W_DEF  = 32;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    LAST_SEEN = 2'd1,
    DONE      = 2'd2
  } sar_state_e;

endpackage

// File: rtl/sar_fifo.sv
// Synchronous FIFO with registered occupancy count; callers never push when full
// or pop when empty.
module sar_fifo #(
  parameter int WIDTH = 96,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_wr_data,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_rd_data,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  // NOTE: storage has no reset; valid entries are tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_wr_data;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_rd_data = r_mem[r_rd_ptr];
  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;

endmodule

// File: rtl/store_and_release.sv
// Buffers indexed tuples and releases the head one per controller strobe into an
// output register. Optional head-index checking is enabled by SAR_SEQ_CHECK_EN.
module store_and_release
  import sar_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int IDX_W  = IDX_W_DEF
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_W-1:0]       in_data,
  input  logic [IDX_W-1:0]        in_idx,
  input  logic                    in_last,
  input  logic [IDX_W-1:0]        next,
  output logic                    is_stored,
  input  logic                    release_data,
  output logic                    local_last_processed,
  output logic                    out_valid,
  output logic [DATA_W-1:0]       out_data,
  input  logic                    out_ready,
  output logic                    proto_error,
  output logic                    seq_error,
  output logic [$clog2(DEPTH):0]  occupancy
);

`ifdef SAR_SEQ_CHECK_EN
  localparam int ENTRY_W = DATA_W + IDX_W;
`else
  localparam int ENTRY_W = DATA_W;
`endif

  sar_state_e          r_state, w_state_nxt;
  logic                r_rst_done;
  logic                r_out_valid;
  logic [DATA_W-1:0]   r_out_data;
  logic                r_proto_error;
  logic [ENTRY_W-1:0]  w_wr_data, w_rd_data;
  logic                w_full, w_empty, w_push, w_pop;
  logic                w_slot_free, w_idx_match;

`ifdef SAR_SEQ_CHECK_EN
  logic              r_seq_error;
  logic [IDX_W-1:0]  w_head_idx;

  assign w_wr_data   = {in_idx, in_data};
  assign w_head_idx  = w_rd_data[DATA_W +: IDX_W];
  assign w_idx_match = (w_head_idx == next);
  assign seq_error   = r_seq_error;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                                   r_seq_error <= 1'b0;
    else if (!w_empty && w_slot_free && !w_idx_match) r_seq_error <= 1'b1;
  end
`else
  logic w_unused_idx;

  assign w_wr_data    = in_data;
  assign w_idx_match  = 1'b1;
  assign seq_error    = 1'b0;
  assign w_unused_idx = ^{in_idx, next};
`endif

  sar_fifo #(.WIDTH(ENTRY_W), .DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (resetn),
    .i_push    (w_push),
    .i_wr_data (w_wr_data),
    .i_pop     (w_pop),
    .o_rd_data (w_rd_data),
    .o_full    (w_full),
    .o_empty   (w_empty),
    .o_count   (occupancy)
  );

  // r_rst_done holds in_ready low until the first edge after reset release.
  assign in_ready    = !w_full && (r_state == RUN) && r_rst_done;
  assign w_push      = in_valid && in_ready;
  assign w_slot_free = !r_out_valid || out_ready;
  assign is_stored   = !w_empty && w_slot_free && w_idx_match;
  assign w_pop       = release_data && is_stored;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state       <= RUN;
      r_rst_done    <= 1'b0;
      r_out_valid   <= 1'b0;
      r_out_data    <= '0;
      r_proto_error <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_rst_done <= 1'b1;
      if (w_pop) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_rd_data[DATA_W-1:0];
      end else if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end
      if (release_data && !is_stored) r_proto_error <= 1'b1;
    end
  end

  // NOTE: default assignment first so every path assigns w_state_nxt (no latch).
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      RUN:       if (w_push && in_last) w_state_nxt = LAST_SEEN;
      LAST_SEEN: if (w_empty)           w_state_nxt = DONE;
      DONE:                             w_state_nxt = DONE;
      default:                          w_state_nxt = RUN;
    endcase
  end

  assign local_last_processed = (r_state == DONE);
  assign out_valid            = r_out_valid;
  assign out_data             = r_out_data;
  assign proto_error          = r_proto_error;

endmodule

// File: tb/tb_store_and_release.sv
// Scoreboard bench for store_and_release: released payloads are queued at push
// time and compared as they leave the output register.
module tb_store_and_release;

  localparam int DATA_W = 64;
  localparam int DEPTH  = 8;
  localparam int IDX_W  = 32;
  localparam int OCC_W  = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              resetn;
  logic              in_valid, in_ready, in_last;
  logic [DATA_W-1:0] in_data;
  logic [IDX_W-1:0]  in_idx, next;
  logic              is_stored, release_data, local_last_processed;
  logic              out_valid, out_ready, proto_error, seq_error;
  logic [DATA_W-1:0] out_data;
  logic [OCC_W-1:0]  occupancy;

  int n_checks = 0;
  int n_fail   = 0;
  logic [DATA_W-1:0] q_exp [$];

  store_and_release #(.DATA_W(DATA_W), .DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
    .clk                  (clk),
    .resetn               (resetn),
    .in_valid             (in_valid),
    .in_ready             (in_ready),
    .in_data              (in_data),
    .in_idx               (in_idx),
    .in_last              (in_last),
    .next                 (next),
    .is_stored            (is_stored),
    .release_data         (release_data),
    .local_last_processed (local_last_processed),
    .out_valid            (out_valid),
    .out_data             (out_data),
    .out_ready            (out_ready),
    .proto_error          (proto_error),
    .seq_error            (seq_error),
    .occupancy            (occupancy)
  );

  always #5 clk = ~clk;

  // Output monitor: every transfer must match the oldest queued payload.
  always @(negedge clk) begin
    logic [DATA_W-1:0] exp_d;
    if (resetn && out_valid && out_ready) begin
      n_checks++;
      if (q_exp.size() == 0) begin
        n_fail++;
        $display("FAIL out_unexpected: out_data=%h with nothing expected", out_data);
      end else begin
        exp_d = q_exp.pop_front();
        if (out_data !== exp_d) begin
          n_fail++;
          $display("FAIL out_data: got %h want %h", out_data, exp_d);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    in_valid = 1'b0; in_data = '0; in_idx = '0; in_last = 1'b0;
    next = '0; release_data = 1'b0; out_ready = 1'b1;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    clear_inputs();
    q_exp.delete();
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    step();
  endtask

  task automatic push_tuple(input logic [DATA_W-1:0] d, input logic [IDX_W-1:0] idx,
                            input logic last);
    in_valid = 1'b1; in_data = d; in_idx = idx; in_last = last;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL push_ready: in_ready=%b want 1 (data %h)", in_ready, d);
    end
    q_exp.push_back(d);
    step();
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic check_occ(input string name, input int want);
    n_checks++;
    if (occupancy !== OCC_W'(want)) begin
      n_fail++;
      $display("FAIL %s: occupancy=%0d want %0d", name, occupancy, want);
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    clear_inputs();
    #3;
    n_checks++;
    if ({in_ready, out_valid, is_stored, local_last_processed, proto_error, seq_error} !== 6'b0
        || out_data !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: rdy/ov/st/llp/pe/se=%b%b%b%b%b%b data=%h want all 0",
               in_ready, out_valid, is_stored, local_last_processed, proto_error, seq_error, out_data);
    end
    check_occ("reset_occ", 0);
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release_ready: in_ready=%b want 0 before first edge", in_ready);
    end
    step();
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready_rise: in_ready=%b want 1", in_ready);
    end
  endtask

  task automatic test_basic();
    do_reset();
    for (int i = 0; i < 3; i++) push_tuple(64'hA0 + 64'(i), IDX_W'(i), 1'b0);
    @(negedge clk);
    check_occ("basic_occ", 3);
    step();
    for (int i = 0; i < 3; i++) begin
      next = IDX_W'(i);
      release_data = 1'b1;
      @(negedge clk);
      n_checks++;
      if (is_stored !== 1'b1 || (i > 0 && out_valid !== 1'b1)) begin
        n_fail++;
        $display("FAIL basic_release%0d: is_stored=%b out_valid=%b want 1/1", i, is_stored, out_valid);
      end
      step();
    end
    release_data = 1'b0;
    next = IDX_W'(3);
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_latency: out_valid=%b want 1", out_valid);
    end
    check_occ("basic_drained", 0);
    step();
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0 || q_exp.size() != 0) begin
      n_fail++;
      $display("FAIL basic_done: out_valid=%b pending=%0d want 0/0", out_valid, q_exp.size());
    end
    step();
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < DEPTH; i++) push_tuple(64'hB0 + 64'(i), IDX_W'(i), 1'b0);
    @(negedge clk);
    check_occ("full_occ", DEPTH);
    in_valid = 1'b1; in_data = 64'hBF; in_idx = IDX_W'(DEPTH);
    release_data = 1'b1; next = '0;
    #1;
    n_checks++;
    if (in_ready !== 1'b0 || is_stored !== 1'b1) begin
      n_fail++;
      $display("FAIL full_push_pop: in_ready=%b is_stored=%b want 0/1", in_ready, is_stored);
    end
    step();
    in_valid = 1'b0; release_data = 1'b0;
    @(negedge clk);
    check_occ("full_refused", DEPTH - 1);
    step();
    push_tuple(64'hB8, IDX_W'(DEPTH), 1'b0);
    for (int k = 1; k <= DEPTH; k++) begin
      next = IDX_W'(k);
      release_data = 1'b1;
      step();
    end
    release_data = 1'b0;
    step();
    @(negedge clk);
    n_checks++;
    if (q_exp.size() != 0 || occupancy !== '0) begin
      n_fail++;
      $display("FAIL full_wrap_drain: pending=%0d occupancy=%0d want 0/0", q_exp.size(), occupancy);
    end
    step();
  endtask

  task automatic test_backpressure();
    do_reset();
    push_tuple(64'hC0, 0, 1'b0);
    push_tuple(64'hC1, 1, 1'b0);
    out_ready = 1'b0; release_data = 1'b1; next = '0;
    step();
    release_data = 1'b0; next = 1;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b1 || is_stored !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_stall: out_valid=%b is_stored=%b want 1/0", out_valid, is_stored);
    end
    check_occ("bp_occ", 1);
    release_data = 1'b1;
    step();
    release_data = 1'b0;
    @(negedge clk);
    n_checks++;
    if (proto_error !== 1'b1 || out_data !== 64'hC0) begin
      n_fail++;
      $display("FAIL bp_proto: proto_error=%b out_data=%h want 1/c0", proto_error, out_data);
    end
    check_occ("bp_occ_hold", 1);
    step();
    out_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (is_stored !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_resume: is_stored=%b want 1", is_stored);
    end
    release_data = 1'b1;
    step();
    release_data = 1'b0; next = 2;
    step();
    @(negedge clk);
    n_checks++;
    if (q_exp.size() != 0 || proto_error !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_done: pending=%0d proto_error=%b want 0/1", q_exp.size(), proto_error);
    end
    step();
  endtask

  task automatic test_last();
    do_reset();
    next = 5;
    push_tuple(64'hD5, 5, 1'b1);
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b0 || local_last_processed !== 1'b0 || is_stored !== 1'b1) begin
      n_fail++;
      $display("FAIL last_seen: in_ready=%b llp=%b is_stored=%b want 0/0/1",
               in_ready, local_last_processed, is_stored);
    end
    release_data = 1'b1;
    step();
    release_data = 1'b0; next = 6;
    @(negedge clk);
    check_occ("last_occ", 0);
    step();
    @(negedge clk);
    n_checks++;
    if (local_last_processed !== 1'b1 || in_ready !== 1'b0 || q_exp.size() != 0) begin
      n_fail++;
      $display("FAIL last_done: llp=%b in_ready=%b pending=%0d want 1/0/0",
               local_last_processed, in_ready, q_exp.size());
    end
    step();
  endtask

  task automatic test_seq();
    logic exp_stored, exp_err;
`ifdef SAR_SEQ_CHECK_EN
    exp_stored = 1'b0; exp_err = 1'b1;
`else
    exp_stored = 1'b1; exp_err = 1'b0;
`endif
    do_reset();
    next = 4;
    push_tuple(64'hE3, 3, 1'b0);
    @(negedge clk);
    n_checks++;
    if (is_stored !== exp_stored) begin
      n_fail++;
      $display("FAIL seq_is_stored: is_stored=%b want %b", is_stored, exp_stored);
    end
    step();
    @(negedge clk);
    n_checks++;
    if (seq_error !== exp_err) begin
      n_fail++;
      $display("FAIL seq_error: seq_error=%b want %b", seq_error, exp_err);
    end
    step();
  endtask

  task automatic test_mid_reset();
    do_reset();
    for (int i = 0; i < 5; i++) push_tuple(64'hF0 + 64'(i), IDX_W'(i), 1'b0);
    release_data = 1'b1; next = '0;
    step();
    release_data = 1'b0; out_ready = 1'b0; next = 1;
    @(negedge clk);
    check_occ("mid_occ", 4);
    step();
    resetn = 1'b0;
    #1;
    n_checks++;
    if ({in_ready, out_valid, is_stored, local_last_processed, proto_error, seq_error} !== 6'b0
        || out_data !== '0 || occupancy !== '0) begin
      n_fail++;
      $display("FAIL mid_reset: rdy/ov/st/llp/pe/se=%b%b%b%b%b%b data=%h occ=%0d want all 0",
               in_ready, out_valid, is_stored, local_last_processed, proto_error, seq_error,
               out_data, occupancy);
    end
    q_exp.delete();
    clear_inputs();
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    step();
    @(negedge clk);
    n_checks++;
    if (occupancy !== '0 || in_ready !== 1'b1 || local_last_processed !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_recover: occ=%0d in_ready=%b llp=%b want 0/1/0",
               occupancy, in_ready, local_last_processed);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full();
    test_backpressure();
    test_last();
    test_seq();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/store_and_release.md
STORE_AND_RELEASE -- requirements
Module: store_and_release

Interface
REQ-001 Parameter DATA_W, 64, tuple payload width.
REQ-002 Parameter DEPTH, 8, buffer entries; power of two, >=2.
REQ-003 Parameter IDX_W, 32, tuple sequence-index width; matches the controller's next counter.
REQ-004 clk  in  1  single clock, all state on rising edge.
REQ-005 resetn  in  1  asynchronous, active-low reset.
REQ-006 in_valid  in  1  input tuple valid.
REQ-007 in_ready  out  1  buffer can accept a tuple.
REQ-008 in_data  in  DATA_W  tuple payload.
REQ-009 in_idx  in  IDX_W  tuple sequence index.
REQ-010 in_last  in  1  tuple is this lane's final tuple.
REQ-011 next  in  IDX_W  controller's index of the tuple to release next.
REQ-012 is_stored  out  1  head tuple is ready for release (to controller).
REQ-013 release_data  in  1  controller release strobe, one cycle per tuple.
REQ-014 local_last_processed  out  1  final tuple accepted and buffer empty.
REQ-015 out_valid  out  1  output register holds a released tuple.
REQ-016 out_data  out  DATA_W  released payload.
REQ-017 out_ready  in  1  downstream accepts out_data.
REQ-018 proto_error  out  1  sticky: release_data seen while is_stored low.
REQ-019 seq_error  out  1  sticky: head index differs from next (macro-gated).
REQ-020 occupancy  out  $clog2(DEPTH)+1  entries currently buffered.

Function
REQ-021 Input handshake: push when in_valid && in_ready; in_ready = !full && state==RUN (registered state, no combinational path from in_valid).
REQ-022 slot_free = !out_valid || out_ready; is_stored = !empty && slot_free && idx_match, combinational from registered state plus out_ready and next.
REQ-023 Pop when release_data && is_stored; the head payload loads out_data/out_valid at the next edge (1-cycle latency); the controller advances next at that same edge.
REQ-024 out_valid clears on out_valid && out_ready unless a pop reloads it in the same cycle.
REQ-025 Push and pop in the same cycle: occupancy unchanged; a full buffer with a pop still refuses the push (in_ready depends only on full).
REQ-026 Pointers wrap modulo DEPTH; occupancy ranges 0..DEPTH; full = occupancy==DEPTH.
REQ-027 State machine RUN -> LAST_SEEN on accepting a tuple with in_last=1; LAST_SEEN -> DONE when the buffer is empty; DONE is terminal until reset.
REQ-028 A push with in_last=1 on an empty buffer moves RUN -> LAST_SEEN; DONE follows once the tuple is popped.
REQ-029 local_last_processed = (state==DONE); a pending output register does not block DONE.
REQ-030 release_data while is_stored=0: no pop, proto_error set, held until reset.
REQ-031 Index comparison uses the full IDX_W; no modular or ordering interpretation.

Reset
REQ-032 resetn low asynchronously clears pointers and occupancy, sets out_valid, is_stored, in_ready, local_last_processed, proto_error, seq_error to 0, out_data to 0, and state to RUN; buffered tuples are discarded, including mid-operation.
REQ-033 in_ready rises no earlier than the first edge after resetn deasserts.

Configuration
REQ-034 Macro SAR_SEQ_CHECK_EN defined: each entry stores in_idx; idx_match = (head_idx == next); seq_error sets when !empty && slot_free && head_idx != next.
REQ-035 Macro SAR_SEQ_CHECK_EN undefined: no index storage, in_idx ignored, idx_match = 1, seq_error tied 0.

Structure
REQ-036 Package sar_pkg holds the state enum (RUN, LAST_SEEN, DONE) and default DATA_W/IDX_W/DEPTH constants.
REQ-037 Sub-module sar_fifo: synchronous FIFO (DEPTH x (DATA_W+IDX_W)) with push/pop/full/empty/count; store_and_release adds the handshake, output register and state machine.

Verification
REQ-038 Reset, then push idx 0..2 with data 0xA0..0xA2, next=0, release when is_stored -> out_data 0xA0,0xA1,0xA2 on consecutive cycles, each one cycle after its release.
REQ-039 Push 8 tuples with DEPTH=8 -> in_ready=0, occupancy=8; a pop plus an offered push in the same cycle -> push refused, occupancy=7.
REQ-040 Hold out_ready=0 with out_valid=1 -> is_stored=0 while the buffer is non-empty; release_data pulse -> proto_error=1 and occupancy unchanged.
REQ-041 Push idx 5 with in_last=1, release it -> state LAST_SEEN, then DONE, local_last_processed=1, in_ready=0.
REQ-042 With SAR_SEQ_CHECK_EN: head idx 3, next=4 -> is_stored=0, seq_error=1; without the macro -> is_stored=1, seq_error=0.
REQ-043 Assert resetn low mid-stream with occupancy=4 -> all outputs 0 immediately; after release, occupancy=0 and state RUN.
